// File: rtl/counter_scheduler.sv
// counter_scheduler: shares one WIDTH-bit up-counter between two requesters.
// Round-robin grant, timed run of len ticks (0 means 2^WIDTH), and a one-cycle
// done pulse to the owner. An owner dropping req aborts the run without done.
module counter_scheduler #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_term,  w_term_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_prio,  w_prio_nxt;
  logic             w_win;

  // Arbitration: a lone requester wins; on a tie the favoured side (r_prio) wins.
  always_comb begin
    w_win = req[1];
    if (req == 2'b11) begin
      w_win = r_prio;
    end
  end

  // Next-state, counter and bookkeeping logic.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_term_nxt  = r_term;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_RUN;
          w_owner_nxt = w_win;
          w_count_nxt = '0;
          // len-1 wraps, so len 0 yields all-ones and a full 2^WIDTH tick run
          w_term_nxt  = (w_win ? len1 : len0) - ONE;
        end
      end
      S_RUN: begin
        // abort wins over reaching the terminal count
        if (!req[r_owner]) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == r_term) begin
          w_state_nxt = S_DONE;
          w_prio_nxt  = ~r_owner;
        end else begin
          w_count_nxt = r_count + ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_term  <= '0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_term  <= w_term_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    gnt   = '0;
    done  = '0;
    busy  = (r_state != S_IDLE);
    count = r_count;
    if (r_state == S_RUN) begin
      gnt = r_owner ? 2'b10 : 2'b01;
    end
    if (r_state == S_DONE) begin
      done = r_owner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Arbitrates shared use of one WIDTH-bit up-counter between two requesters.
- Each requester asks for a timed run of len ticks; the block grants one requester at a time (round-robin), counts from 0 to len-1, and pulses done to the winner.
- Sits beside the testbench clock/reset and gives the counter datapath a sequenced, shared owner instead of a free-running count.

Parameters:
- WIDTH, 5, counter and length width; run length 0 means 2^WIDTH ticks.

Ports:
- clock  input  1  single clock, all state on posedge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- req  input  2  req[i] high = requester i wants / holds the counter; must stay high until done[i]
- len0  input  WIDTH  run length for requester 0, sampled at grant
- len1  input  WIDTH  run length for requester 1, sampled at grant
- gnt  output  2  one-hot grant, high for every RUN cycle of the owner
- busy  output  1  high in RUN and DONE
- count  output  WIDTH  current counter value
- done  output  2  one-cycle completion pulse to the owner

Behaviour:
- Reset (reset=0, async): state=IDLE; gnt=0, busy=0, count=0, done=0; rr pointer favours req0; latched length=0; owner=0.
- States: IDLE, RUN, DONE (2-bit encoding, registered).
- IDLE:
  - req==0: stay; count holds its last value.
  - Any req: pick the winner; next cycle state=RUN, gnt[w]=1, count=0, term=len_w-1 (WIDTH-bit wrap, so len 0 gives term=all-ones, 2^WIDTH ticks).
- Arbitration:
  - Single requester wins.
  - Both requesting: winner is the one not granted last (rr pointer); after reset req0 wins.
  - Pointer updates only when a run reaches DONE; aborted runs do not move it.
- RUN: count increments by 1 each cycle (modulo 2^WIDTH).
  - count==term and req[owner]=1: next state=DONE, gnt=0, done[owner]=1, count holds term.
  - req[owner] drops (abort): next state=IDLE, gnt=0, no done, count holds value. Abort takes priority over terminal on the same cycle.
  - Other requester's req is ignored during RUN (no preemption).
- DONE: one cycle only; done[owner]=1, busy=1, gnt=0; next state=IDLE; done clears.
- Latency:
  - req seen in IDLE at edge k: gnt and count=0 visible after k+1.
  - Length L: gnt high for exactly L cycles (count 0..L-1); done pulse follows the last gnt cycle; IDLE one cycle later.
  - Earliest next grant is 1 cycle after re-entering IDLE, giving a 2-cycle gap between consecutive gnt windows.
- Requester keeping req high after done is re-arbitrated as a new request.
- len inputs are sampled only at grant; changes during RUN are ignored.
- Invariants: gnt and done are each one-hot or zero; gnt&done==0; busy = (state!=IDLE).
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; no done pulse emitted.

Test Plan:
- Reset then req=2'b01, len0=3 → gnt=01 for 3 cycles with count 0,1,2; done=01 for one cycle; count stays 2; busy drops the cycle after done.
- req=2'b11 held, len0=2, len1=4 → grant order req0 (2 cycles), done0, req1 (4 cycles), done1, req0 again; gap of 2 non-gnt cycles between windows.
- req=2'b10, len1=0 → gnt=10 for 32 cycles, count 0..31; done=10 when count=31; no early termination at wrap.
- req0 granted with len0=10, req0 dropped when count=4 → gnt clears next cycle, done never pulses, count holds 4; pending req1 granted after IDLE; rr pointer unchanged (req0 wins next tie).
- reset driven low asynchronously mid-run (count=7, gnt=01) → gnt, busy, count, done all 0 without a clock edge; after release with req=11, req0 granted first.
- len0 changed from 5 to 2 during an active run → run still lasts 5 cycles (count reaches 4 before done).
